pipereg_elastic: RTL

PIPEREG_ELASTIC -- requirements
Module: pipereg_elastic

---
 rtl/pipereg_elastic.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipereg_elastic.sv
// Elastic two-entry pipeline register (main + skid) with valid/ready handshakes,
// a registered up_ready, bubble-masked control output and a saturating stall counter.
module pipereg_elastic #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                up_ready_reg;
  logic [DATA_W-1:0]   main_data_reg, skid_data_reg;
  logic [CTRL_W-1:0]   main_ctrl_reg, skid_ctrl_reg;
  logic [15:0]         stall_cnt_reg;

  logic                up_fire, dn_fire;
  logic                main_load, main_from_skid, skid_load;
  logic                stall_inc;

  assign dn_valid  = (state_reg != ST_EMPTY);
  assign up_ready  = up_ready_reg;
  assign dn_data   = main_data_reg;
  assign dn_ctrl   = dn_valid ? main_ctrl_reg : BUBBLE_CTRL;
  assign stall_cnt = stall_cnt_reg;

  assign up_fire   = up_valid & up_ready_reg;
  assign dn_fire   = dn_valid & dn_ready;
  assign stall_inc = dn_valid & ~dn_ready & ~flush & (stall_cnt_reg != 16'hFFFF);

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      // Kill everything held plus any same-cycle accept; payload registers are left as-is.
      state_next = ST_EMPTY;
    end else begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (up_fire) begin
            state_next = ST_ONE;
            main_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (up_fire && dn_fire) begin
            state_next = ST_ONE;
            main_load  = 1'b1;
          end else if (up_fire) begin
            state_next = ST_FULL;
            skid_load  = 1'b1;
          end else if (dn_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dn_fire) begin
            state_next     = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg     <= ST_EMPTY;
      up_ready_reg  <= 1'b1;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Registered from the next state so dn_ready never reaches up_ready combinationally.
      up_ready_reg <= (state_next != ST_FULL);
      if (main_load) begin
        main_data_reg <= main_from_skid ? skid_data_reg : up_data;
        main_ctrl_reg <= main_from_skid ? skid_ctrl_reg : up_ctrl;
      end
      if (skid_load) begin
        skid_data_reg <= up_data;
        skid_ctrl_reg <= up_ctrl;
      end
      if (stall_inc) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

endmodule
